// File: rtl/synthesizer_soc_pkg.sv
// Board-level constants shared by the synthesizer SoC fabric blocks.
package synthesizer_soc_pkg;

    localparam int unsigned CLK_HZ              = 32'd50_000_000;
    localparam int unsigned KEY_DEBOUNCE_MS     = 32'd10;
    localparam int unsigned KEY_DEBOUNCE_CYCLES = (CLK_HZ / 32'd1000) * KEY_DEBOUNCE_MS;
    localparam int unsigned NUM_KEYS            = 32'd2;

    // Level a key pin rests at when the button is not pressed.
    function automatic logic key_released_level(input bit active_low);
        if (active_low) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/synthesizer_soc_key_debounce_ch.sv
// One key channel: 2-flop synchroniser, hold counter, accepted level and edge pulses.
module synthesizer_soc_key_debounce_ch
    import synthesizer_soc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_clean,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          REL_LVL  = key_released_level(ACTIVE_LOW);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Next-state: a new level is accepted only after an unbroken run of DEBOUNCE_CYCLES samples.
    always_comb begin
        s1_d      = key_raw;
        s2_d      = s1_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            stable_d  = s2_q;
            cnt_d     = {CW{1'b0}};
            press_d   = (s2_q != REL_LVL);
            release_d = (s2_q == REL_LVL);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers; reset parks everything at the released level with no pulse pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= REL_LVL;
            s2_q      <= REL_LVL;
            stable_q  <= REL_LVL;
            cnt_q     <= {CW{1'b0}};
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_clean   = stable_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/synthesizer_soc_key_debounce.sv
// Debounces the board push-buttons for the key PIO and emits press/release pulses.
module synthesizer_soc_key_debounce
    import synthesizer_soc_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = synthesizer_soc_pkg::NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_ch
        synthesizer_soc_key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[g]),
            .key_clean   (key_clean[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_synthesizer_soc_key_debounce.sv
// Scoreboard bench: stimulus pushes expected pulse events, a negedge monitor pops and checks.
module tb_synthesizer_soc_key_debounce;

    localparam int DC = 8;
    localparam int LAT = DC + 2; // cycle-count offset from drive point to the accepting edge

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] clean;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] key_raw = 2'b11;
    logic [1:0] key_clean, key_press, key_release;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_clean = 2'b11;
    ev_t        q[$];

    synthesizer_soc_key_debounce #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_clean   (key_clean),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [1:0] p, input logic [1:0] r, input logic [1:0] c);
        ev_t e;
        e.cyc = cyc + LAT;
        e.press = p;
        e.rel = r;
        e.clean = c;
        q.push_back(e);
    endtask

    // Monitor: checks reset state, pops an expected event on every pulse, tracks the clean level.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_clean = 2'b11;
            checks++;
            if (key_clean !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00) begin
                failures++;
                $display("FAIL reset_state cyc=%0d clean=%b press=%b rel=%b required clean=11 press=00 rel=00",
                         cyc, key_clean, key_press, key_release);
            end
        end else begin
            if ((key_press | key_release) !== 2'b00) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b required none",
                             cyc, key_press, key_release);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    exp_clean = e.clean;
                    if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release) begin
                        failures++;
                        $display("FAIL pulse_event cyc=%0d press=%b rel=%b required cyc=%0d press=%b rel=%b",
                                 cyc, key_press, key_release, e.cyc, e.press, e.rel);
                    end
                end
            end
            checks++;
            if (key_clean !== exp_clean) begin
                failures++;
                $display("FAIL key_clean cyc=%0d got=%b required=%b", cyc, key_clean, exp_clean);
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int last;
        key_raw = 2'b11;
        reset_n = 1'b0;
        wait_cycles(4);
        reset_n = 1'b1;

        // 1: idle after reset, no pulses for 50 cycles
        wait_cycles(50);

        // 2: clean press of key 0
        key_raw = 2'b10;
        expect_ev(2'b01, 2'b00, 2'b10);
        wait_cycles(20);

        // release key 0 to prepare the bounce test
        key_raw = 2'b11;
        expect_ev(2'b00, 2'b01, 2'b11);
        wait_cycles(20);

        // 3: key 0 bounces every 3 cycles, then settles low
        last = 0;
        for (int i = 0; i < 13; i++) begin
            key_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            last = cyc;
            wait_cycles(3);
        end
        q.push_back('{cyc: last + LAT, press: 2'b01, rel: 2'b00, clean: 2'b10});
        wait_cycles(20);

        // press key 1 so both are held
        key_raw = 2'b00;
        expect_ev(2'b10, 2'b00, 2'b00);
        wait_cycles(20);

        // 4: simultaneous release of both keys
        key_raw = 2'b11;
        expect_ev(2'b00, 2'b11, 2'b11);
        wait_cycles(20);

        // 5: reset mid-count on key 1, key held through reset
        key_raw = 2'b01;
        wait_cycles(7);
        reset_n = 1'b0;
        #1;
        checks++;
        if (key_clean !== 2'b11 || key_press !== 2'b00) begin
            failures++;
            $display("FAIL async_reset clean=%b press=%b required clean=11 press=00", key_clean, key_press);
        end
        wait_cycles(3);
        reset_n = 1'b1;
        expect_ev(2'b10, 2'b00, 2'b01);
        wait_cycles(20);

        // release key 1 before the glitch test
        key_raw = 2'b11;
        expect_ev(2'b00, 2'b10, 2'b11);
        wait_cycles(20);

        // 6: 7-cycle glitch on key 1 must be rejected
        key_raw[1] = 1'b0;
        wait_cycles(7);
        key_raw[1] = 1'b1;
        wait_cycles(30);

        for (int i = 0; i < 200 && q.size() != 0; i++) wait_cycles(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_events pending=%0d required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
